// File: rtl/pixel_stream_tracker.sv
// pixel_stream_tracker
// Registers a valid-qualified pixel stream and tags each accepted pixel with
// its column (i) and row (j). Frame/Line markers start a frame/row; with
// AUTO_LINE set, a row also wraps after WIDTH pixels. Pixels that do not fit
// the configured geometry are dropped and raise the sticky OvfErr flag.
//
// Ports
//   Clk        : clock, all state updates on the rising edge
//   Reset      : synchronous, active-high
//   Pixel      : input pixel (DATA_W)
//   PixelValid : Pixel, Frame and Line are valid this cycle
//   Frame      : this pixel is the first of a frame
//   Line       : this pixel is the first of a line
//   FrameOut   : Frame delayed by one cycle, independent of PixelValid
//   data       : registered pixel
//   DataValid  : data/i/j carry a newly accepted pixel
//   i, j       : column / row of data
//   LineEnd    : data is the last pixel of its line (i == WIDTH-1)
//   FrameEnd   : data is the last pixel of the frame
//   OvfErr     : sticky geometry error, cleared by Reset or a Frame pixel
module pixel_stream_tracker #(
    parameter int DATA_W    = 8,
    parameter int X_W       = 8,
    parameter int Y_W       = 8,
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 256,
    parameter int AUTO_LINE = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Pixel,
    input  logic              PixelValid,
    input  logic              Frame,
    input  logic              Line,
    output logic              FrameOut,
    output logic [DATA_W-1:0] data,
    output logic              DataValid,
    output logic [X_W-1:0]    i,
    output logic [Y_W-1:0]    j,
    output logic              LineEnd,
    output logic              FrameEnd,
    output logic              OvfErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // col holds the column of the next pixel and may reach WIDTH, hence X_W+1 bits.
    localparam logic [X_W:0]   COL_WIDTH = (X_W + 1)'(WIDTH);
    localparam logic [X_W-1:0] LAST_I    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] LAST_J    = Y_W'(HEIGHT - 1);

    state_t              state_q, state_d;
    logic [X_W:0]        col_q, col_d;
    logic [Y_W-1:0]      row_q, row_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [X_W-1:0]      i_q, i_d;
    logic [Y_W-1:0]      j_q, j_d;
    logic                dv_q, dv_d;
    logic                le_q, le_d;
    logic                fe_q, fe_d;
    logic                ovf_q, ovf_d;
    logic                fo_q, fo_d;

    logic                accept;
    logic                new_line;
    logic [X_W-1:0]      acc_i;
    logic [Y_W-1:0]      acc_j;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        data_d   = data_q;
        i_d      = i_q;
        j_d      = j_q;
        dv_d     = 1'b0;
        le_d     = 1'b0;
        fe_d     = 1'b0;
        ovf_d    = ovf_q;
        fo_d     = Frame;
        accept   = 1'b0;
        acc_i    = '0;
        acc_j    = '0;
        // A row wrap is either an explicit Line marker or, with AUTO_LINE,
        // a pixel arriving once the current row is already full.
        new_line = Line || ((AUTO_LINE != 0) && (col_q == COL_WIDTH));

        if (PixelValid) begin
            if (Frame) begin
                // Frame wins over Line and is honoured in every state.
                accept  = 1'b1;
                ovf_d   = 1'b0;
                col_d   = (X_W + 1)'(1);
                row_d   = '0;
                state_d = ACTIVE;
            end else begin
                case (state_q)
                    ACTIVE: begin
                        if (new_line) begin
                            if (row_q == LAST_J) begin
                                ovf_d   = 1'b1;
                                state_d = DONE;
                            end else begin
                                accept = 1'b1;
                                acc_j  = row_q + Y_W'(1);
                                col_d  = (X_W + 1)'(1);
                                row_d  = row_q + Y_W'(1);
                            end
                        end else if (col_q < COL_WIDTH) begin
                            accept = 1'b1;
                            acc_i  = col_q[X_W-1:0];
                            acc_j  = row_q;
                            col_d  = col_q + (X_W + 1)'(1);
                        end else begin
                            // Row full and no wrap allowed: drop, keep state.
                            ovf_d = 1'b1;
                        end
                    end
                    DONE:    ovf_d = 1'b1;
                    default: ;  // IDLE: pixels outside a frame are ignored
                endcase
            end
        end

        if (accept) begin
            data_d = Pixel;
            i_d    = acc_i;
            j_d    = acc_j;
            dv_d   = 1'b1;
            le_d   = (acc_i == LAST_I);
            fe_d   = (acc_i == LAST_I) && (acc_j == LAST_J);
            if ((acc_i == LAST_I) && (acc_j == LAST_J)) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            dv_q    <= 1'b0;
            le_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovf_q   <= 1'b0;
            fo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            data_q  <= data_d;
            i_q     <= i_d;
            j_q     <= j_d;
            dv_q    <= dv_d;
            le_q    <= le_d;
            fe_q    <= fe_d;
            ovf_q   <= ovf_d;
            fo_q    <= fo_d;
        end
    end

    assign FrameOut  = fo_q;
    assign data      = data_q;
    assign DataValid = dv_q;
    assign i         = i_q;
    assign j         = j_q;
    assign LineEnd   = le_q;
    assign FrameEnd  = fe_q;
    assign OvfErr    = ovf_q;

endmodule

// File: tb/tb_pixel_stream_tracker.sv
// Bench for pixel_stream_tracker: three instances share one input stream
//   0: WIDTH=4 HEIGHT=2 AUTO_LINE=1
//   1: WIDTH=4 HEIGHT=2 AUTO_LINE=0
//   2: WIDTH=1 HEIGHT=1 AUTO_LINE=1
// and each is compared every cycle against a behavioural geometry model.
module tb_pixel_stream_tracker;

    localparam int N = 3;
    localparam int CW [N] = '{4, 4, 1};
    localparam int CH [N] = '{2, 2, 1};
    localparam int CA [N] = '{1, 0, 1};

    logic       Clk;
    logic       Reset;
    logic [7:0] Pixel;
    logic       PixelValid;
    logic       Frame;
    logic       Line;

    logic       o_fo  [N];
    logic [7:0] o_data[N];
    logic       o_dv  [N];
    logic [1:0] o_i   [N];
    logic [0:0] o_j   [N];
    logic       o_le  [N];
    logic       o_fe  [N];
    logic       o_ovf [N];

    pixel_stream_tracker #(.DATA_W(8), .X_W(2), .Y_W(1), .WIDTH(4), .HEIGHT(2), .AUTO_LINE(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Pixel(Pixel), .PixelValid(PixelValid), .Frame(Frame), .Line(Line),
        .FrameOut(o_fo[0]), .data(o_data[0]), .DataValid(o_dv[0]), .i(o_i[0]), .j(o_j[0]),
        .LineEnd(o_le[0]), .FrameEnd(o_fe[0]), .OvfErr(o_ovf[0]));

    pixel_stream_tracker #(.DATA_W(8), .X_W(2), .Y_W(1), .WIDTH(4), .HEIGHT(2), .AUTO_LINE(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Pixel(Pixel), .PixelValid(PixelValid), .Frame(Frame), .Line(Line),
        .FrameOut(o_fo[1]), .data(o_data[1]), .DataValid(o_dv[1]), .i(o_i[1]), .j(o_j[1]),
        .LineEnd(o_le[1]), .FrameEnd(o_fe[1]), .OvfErr(o_ovf[1]));

    pixel_stream_tracker #(.DATA_W(8), .X_W(2), .Y_W(1), .WIDTH(1), .HEIGHT(1), .AUTO_LINE(1)) dut_c (
        .Clk(Clk), .Reset(Reset), .Pixel(Pixel), .PixelValid(PixelValid), .Frame(Frame), .Line(Line),
        .FrameOut(o_fo[2]), .data(o_data[2]), .DataValid(o_dv[2]), .i(o_i[2]), .j(o_j[2]),
        .LineEnd(o_le[2]), .FrameEnd(o_fe[2]), .OvfErr(o_ovf[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: in_frame/finished describe where we are in the frame,
    // nx/ny is the coordinate the next pixel would get.
    bit   in_frame [N];
    bit   finished [N];
    int   nx [N];
    int   ny [N];
    bit   e_ovf [N];
    bit   e_fo  [N];
    bit   e_dv  [N];
    bit   e_le  [N];
    bit   e_fe  [N];
    int   e_i   [N];
    int   e_j   [N];
    int   e_data[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        in_frame[k] = 0; finished[k] = 0; nx[k] = 0; ny[k] = 0;
        e_ovf[k] = 0; e_fo[k] = 0; e_dv[k] = 0; e_le[k] = 0; e_fe[k] = 0;
        e_i[k] = 0; e_j[k] = 0; e_data[k] = 0;
    endtask

    task automatic emit(input int k, input int x, input int y);
        e_dv[k]   = 1;
        e_data[k] = int'(Pixel);
        e_i[k]    = x;
        e_j[k]    = y;
        e_le[k]   = (x == CW[k] - 1);
        e_fe[k]   = (x == CW[k] - 1) && (y == CH[k] - 1);
        if (e_fe[k]) begin
            in_frame[k] = 0;
            finished[k] = 1;
        end
    endtask

    task automatic model_step(input int k);
        bit wrap;
        e_fo[k] = Frame;
        e_dv[k] = 0; e_le[k] = 0; e_fe[k] = 0;
        if (PixelValid) begin
            if (Frame) begin
                in_frame[k] = 1; finished[k] = 0; e_ovf[k] = 0;
                nx[k] = 1; ny[k] = 0;
                emit(k, 0, 0);
            end else if (in_frame[k]) begin
                wrap = Line || (CA[k] != 0 && nx[k] == CW[k]);
                if (wrap) begin
                    if (ny[k] + 1 >= CH[k]) begin
                        e_ovf[k] = 1; in_frame[k] = 0; finished[k] = 1;
                    end else begin
                        ny[k] = ny[k] + 1; nx[k] = 1;
                        emit(k, 0, ny[k]);
                    end
                end else if (nx[k] < CW[k]) begin
                    nx[k] = nx[k] + 1;
                    emit(k, nx[k] - 1, ny[k]);
                end else begin
                    e_ovf[k] = 1;
                end
            end else if (finished[k]) begin
                e_ovf[k] = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("FrameOut%0d", k),  32'(o_fo[k]),   32'(e_fo[k]));
            check($sformatf("DataValid%0d", k), 32'(o_dv[k]),   32'(e_dv[k]));
            check($sformatf("data%0d", k),      32'(o_data[k]), 32'(e_data[k]));
            check($sformatf("i%0d", k),         32'(o_i[k]),    32'(e_i[k]));
            check($sformatf("j%0d", k),         32'(o_j[k]),    32'(e_j[k]));
            check($sformatf("LineEnd%0d", k),   32'(o_le[k]),   32'(e_le[k]));
            check($sformatf("FrameEnd%0d", k),  32'(o_fe[k]),   32'(e_fe[k]));
            check($sformatf("OvfErr%0d", k),    32'(o_ovf[k]),  32'(e_ovf[k]));
        end
    endtask

    task automatic cycle(input logic rst, input logic v, input logic f, input logic l, input logic [7:0] pix);
        Reset = rst; PixelValid = v; Frame = f; Line = l; Pixel = pix;
        for (int k = 0; k < N; k++) begin
            if (rst) model_reset(k);
            else     model_step(k);
        end
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    initial begin
        Reset = 1'b1; PixelValid = 1'b0; Frame = 1'b0; Line = 1'b0; Pixel = 8'h00;

        // Reset state
        cycle(1, 0, 0, 0, 8'h00);
        cycle(1, 1, 1, 0, 8'hAA);

        // Full frame with auto-wrap: Frame pixel then seven plain pixels
        cycle(0, 1, 1, 0, 8'h10);
        for (int p = 1; p < 8; p++) cycle(0, 1, 0, 0, 8'(8'h10 + p));
        // Pixel after frame end is dropped, then a new Frame restarts
        cycle(0, 1, 0, 0, 8'h18);
        cycle(0, 0, 0, 0, 8'h00);
        cycle(0, 1, 1, 0, 8'h20);

        // Five pixels in one row without Line, then a Line pixel
        for (int p = 1; p < 5; p++) cycle(0, 1, 0, 0, 8'(8'h20 + p));
        cycle(0, 1, 0, 1, 8'h30);

        // Short line, and Frame+Line together
        cycle(0, 1, 1, 0, 8'h40);
        cycle(0, 1, 0, 0, 8'h41);
        cycle(0, 1, 0, 1, 8'h42);
        cycle(0, 1, 1, 1, 8'h43);

        // PixelValid gap with Frame held high
        cycle(0, 1, 1, 0, 8'h50);
        cycle(0, 0, 1, 0, 8'h51);
        cycle(0, 1, 0, 0, 8'h52);
        cycle(0, 0, 1, 1, 8'h53);
        cycle(0, 1, 0, 0, 8'h54);

        // Reset mid-line, then pixels without Frame are ignored in IDLE
        cycle(1, 1, 0, 0, 8'h60);
        cycle(0, 1, 0, 0, 8'h61);
        cycle(0, 1, 0, 1, 8'h62);
        cycle(0, 1, 0, 0, 8'h63);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            logic r, v, f, l;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 11) == 0);
            l = ($urandom_range(0, 5) == 0);
            cycle(r, v, f, l, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
